// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter
//   Load/store adapter between the execute stage and the data port of the
//   cached memory subsystem. Checks a request for funct3 legality and
//   alignment, forms the word address, byte mask and lane-replicated store
//   data, and holds the matching enable until memory answers. Load data is
//   extracted from its lane and sign/zero extended. An access that gets no
//   answer within TIMEOUT_CYCLES cycles is aborted with an error.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   ex_*                     request from execute (valid, store, funct3, addr, data, rd)
//   lsu_busy                 stall while an access is outstanding
//   resp_valid/is_load/rd/data  one-cycle completion pulse and payload
//   err_valid/err_code       one-cycle error pulse (01 misaligned, 10 funct3, 11 timeout)
//   mem_*_enable, mem_address, mem_mask_vector, mem_write_data   memory request
//   mem_read_done, mem_write_done, mem_read_data                 memory response
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access outstanding; requests accepted or rejected here
// ST_WAIT | enable held, waiting for the matching done or the timeout

module lsu_mem_adapter #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ex_valid,
   input  logic                     ex_is_store,
   input  logic [2:0]               ex_funct3,
   input  logic [ADDRESS_WIDTH-1:0] ex_addr,
   input  logic [DATA_WIDTH-1:0]    ex_store_data,
   input  logic [4:0]               ex_rd,
   output logic                     lsu_busy,
   output logic                     resp_valid,
   output logic                     resp_is_load,
   output logic [4:0]               resp_rd,
   output logic [DATA_WIDTH-1:0]    resp_data,
   output logic                     err_valid,
   output logic [1:0]               err_code,
   output logic                     mem_read_enable,
   output logic                     mem_write_enable,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [3:0]               mem_mask_vector,
   output logic [DATA_WIDTH-1:0]    mem_write_data,
   input  logic                     mem_read_done,
   input  logic                     mem_write_done,
   input  logic [DATA_WIDTH-1:0]    mem_read_data
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t state, state_nxt;

   logic          req_is_load;
   logic [2:0]    req_funct3;
   logic [1:0]    req_off;
   logic [4:0]    req_rd;
   logic [CW-1:0] cnt;

   // request decode
   logic       f3_illegal;
   logic       misaligned;
   logic [3:0] mask_nxt;
   logic [DATA_WIDTH-1:0] wdata_nxt;

   always_comb begin
      f3_illegal = 1'b0;
      misaligned = 1'b0;
      mask_nxt   = 4'b0000;
      wdata_nxt  = ex_store_data;
      case (ex_funct3)
         3'b000, 3'b100: begin
            mask_nxt  = 4'b0001 << ex_addr[1:0];
            wdata_nxt = {4{ex_store_data[7:0]}};
         end
         3'b001, 3'b101: begin
            mask_nxt   = 4'b0011 << ex_addr[1:0];
            wdata_nxt  = {2{ex_store_data[15:0]}};
            misaligned = ex_addr[0];
         end
         3'b010: begin
            mask_nxt   = 4'b1111;
            wdata_nxt  = ex_store_data;
            misaligned = (ex_addr[1:0] != 2'b00);
         end
         default: f3_illegal = 1'b1;
      endcase
      // unsigned widths exist only for loads
      if (ex_is_store && ex_funct3[2])
         f3_illegal = 1'b1;
   end

   // load lane extraction and extension
   logic [DATA_WIDTH-1:0] rd_shift;
   logic [DATA_WIDTH-1:0] load_ext;

   always_comb begin
      rd_shift = mem_read_data >> {req_off, 3'b000};
      case (req_funct3)
         3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  load_ext = {24'd0, rd_shift[7:0]};
         3'b101:  load_ext = {16'd0, rd_shift[15:0]};
         default: load_ext = mem_read_data;
      endcase
   end

   // FSM
   logic accept_ok, accept_err, finish, timeout;
   logic done_match;

   assign done_match = req_is_load ? mem_read_done : mem_write_done;

   always_ff @(posedge clk) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept_ok  = 1'b0;
      accept_err = 1'b0;
      finish     = 1'b0;
      timeout    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ex_valid) begin
               if (f3_illegal || misaligned) begin
                  accept_err = 1'b1;
               end else begin
                  accept_ok = 1'b1;
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // a done in the last cycle still completes the access
            if (done_match) begin
               finish    = 1'b1;
               state_nxt = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
               timeout   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // registered request fields and response pulses
   always_ff @(posedge clk) begin
      if (!rst) begin
         req_is_load     <= 1'b0;
         req_funct3      <= 3'b000;
         req_off         <= 2'b00;
         req_rd          <= 5'd0;
         cnt             <= '0;
         mem_address     <= '0;
         mem_mask_vector <= 4'b0000;
         mem_write_data  <= '0;
         resp_valid      <= 1'b0;
         resp_is_load    <= 1'b0;
         resp_rd         <= 5'd0;
         resp_data       <= '0;
         err_valid       <= 1'b0;
         err_code        <= 2'b00;
      end else begin
         resp_valid <= 1'b0;
         err_valid  <= 1'b0;
         if (accept_err) begin
            err_valid <= 1'b1;
            err_code  <= f3_illegal ? 2'b10 : 2'b01;
         end
         if (accept_ok) begin
            req_is_load     <= !ex_is_store;
            req_funct3      <= ex_funct3;
            req_off         <= ex_addr[1:0];
            req_rd          <= ex_rd;
            cnt             <= '0;
            mem_address     <= {ex_addr[ADDRESS_WIDTH-1:2], 2'b00};
            mem_mask_vector <= mask_nxt;
            mem_write_data  <= wdata_nxt;
         end
         if (finish) begin
            resp_valid   <= 1'b1;
            resp_is_load <= req_is_load;
            resp_rd      <= req_rd;
            resp_data    <= req_is_load ? load_ext : '0;
         end else if (timeout) begin
            err_valid <= 1'b1;
            err_code  <= 2'b11;
         end else if (state == ST_WAIT) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign lsu_busy         = (state == ST_WAIT);
   assign mem_read_enable  = (state == ST_WAIT) &&  req_is_load;
   assign mem_write_enable = (state == ST_WAIT) && !req_is_load;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
module tb_lsu_mem_adapter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_is_store;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_store_data;
   logic [4:0]  ex_rd;
   logic        lsu_busy, resp_valid, resp_is_load;
   logic [4:0]  resp_rd;
   logic [31:0] resp_data;
   logic        err_valid;
   logic [1:0]  err_code;
   logic        mem_read_enable, mem_write_enable;
   logic [31:0] mem_address;
   logic [3:0]  mem_mask_vector;
   logic [31:0] mem_write_data;
   logic        mem_read_done, mem_write_done;
   logic [31:0] mem_read_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lsu_mem_adapter #(
      .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
      .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .lsu_busy(lsu_busy), .resp_valid(resp_valid), .resp_is_load(resp_is_load),
      .resp_rd(resp_rd), .resp_data(resp_data),
      .err_valid(err_valid), .err_code(err_code),
      .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
      .mem_address(mem_address), .mem_mask_vector(mem_mask_vector),
      .mem_write_data(mem_write_data),
      .mem_read_done(mem_read_done), .mem_write_done(mem_write_done),
      .mem_read_data(mem_read_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance one edge; inputs change and outputs are sampled 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic [4:0] rd);
      ex_valid      = 1'b1;
      ex_is_store   = st;
      ex_funct3     = f3;
      ex_addr       = a;
      ex_store_data = d;
      ex_rd         = rd;
   endtask

   task automatic bad_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [1:0] code);
      req(st, f3, a, 32'h0, 5'd0);
      tick();
      ex_valid = 1'b0;
      chk({tag, "_err_valid"}, 32'(err_valid), 32'd1);
      chk({tag, "_err_code"}, 32'(err_code), 32'(code));
      chk({tag, "_busy"}, 32'(lsu_busy), 32'd0);
      chk({tag, "_en"}, 32'({mem_read_enable, mem_write_enable}), 32'd0);
      tick();
      chk({tag, "_err_pulse"}, 32'(err_valid), 32'd0);
      chk({tag, "_en2"}, 32'({mem_read_enable, mem_write_enable}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b0;
      ex_valid = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'b000;
      ex_addr = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd0;
      mem_read_done = 1'b0; mem_write_done = 1'b0; mem_read_data = 32'h0;
      tick(); tick();

      // reset state
      chk("rst_busy", 32'(lsu_busy), 32'd0);
      chk("rst_en", 32'({mem_read_enable, mem_write_enable}), 32'd0);
      chk("rst_pulses", 32'({resp_valid, err_valid}), 32'd0);
      chk("rst_addr", mem_address, 32'h0);
      chk("rst_mask", 32'(mem_mask_vector), 32'h0);
      chk("rst_wdata", mem_write_data, 32'h0);
      chk("rst_rdata", resp_data, 32'h0);
      chk("rst_code", 32'(err_code), 32'h0);
      rst = 1'b1;
      tick();

      // LB at 0x103, memory answers three cycles later
      req(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5);
      tick();
      ex_valid = 1'b0;
      chk("lb_busy", 32'(lsu_busy), 32'd1);
      chk("lb_ren", 32'(mem_read_enable), 32'd1);
      chk("lb_wen", 32'(mem_write_enable), 32'd0);
      chk("lb_addr", mem_address, 32'h0000_0100);
      chk("lb_mask", 32'(mem_mask_vector), 32'h8);
      tick(); tick();
      chk("lb_ren_held", 32'(mem_read_enable), 32'd1);
      chk("lb_no_resp", 32'(resp_valid), 32'd0);
      mem_read_done = 1'b1; mem_read_data = 32'h80FF_1234;
      tick();
      mem_read_done = 1'b0; mem_read_data = 32'h0;
      chk("lb_resp_valid", 32'(resp_valid), 32'd1);
      chk("lb_is_load", 32'(resp_is_load), 32'd1);
      chk("lb_rd", 32'(resp_rd), 32'd5);
      chk("lb_data", resp_data, 32'hFFFF_FF80);
      chk("lb_idle", 32'({lsu_busy, mem_read_enable}), 32'd0);
      tick();
      chk("lb_pulse", 32'(resp_valid), 32'd0);
      chk("lb_hold", resp_data, 32'hFFFF_FF80);

      // SH upper half, wrong done ignored
      req(1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd0);
      tick();
      ex_valid = 1'b0;
      chk("sh_wen", 32'(mem_write_enable), 32'd1);
      chk("sh_ren", 32'(mem_read_enable), 32'd0);
      chk("sh_addr", mem_address, 32'h0000_0200);
      chk("sh_mask", 32'(mem_mask_vector), 32'hC);
      chk("sh_wdata", mem_write_data, 32'hBEEF_BEEF);
      mem_read_done = 1'b1;
      tick();
      mem_read_done = 1'b0;
      chk("sh_wrongdone_wen", 32'(mem_write_enable), 32'd1);
      chk("sh_wrongdone_resp", 32'(resp_valid), 32'd0);
      mem_write_done = 1'b1;
      tick();
      mem_write_done = 1'b0;
      chk("sh_resp_valid", 32'(resp_valid), 32'd1);
      chk("sh_is_load", 32'(resp_is_load), 32'd0);
      chk("sh_data", resp_data, 32'h0);
      chk("sh_wen_drop", 32'(mem_write_enable), 32'd0);
      tick();

      // illegal and misaligned requests
      bad_req("lw_mis", 1'b0, 3'b010, 32'h0000_0101, 2'b01);
      bad_req("lh_mis", 1'b0, 3'b001, 32'h0000_0103, 2'b01);
      bad_req("ld_f3", 1'b0, 3'b011, 32'h0000_0100, 2'b10);
      bad_req("sbu_f3", 1'b1, 3'b100, 32'h0000_0100, 2'b10);
      bad_req("prio_f3", 1'b0, 3'b110, 32'h0000_0103, 2'b10);

      // timeout: enable high for exactly 8 cycles
      req(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd1);
      tick();
      ex_valid = 1'b0;
      k = 0;
      while (mem_read_enable && k < 20) begin
         k++;
         tick();
      end
      chk("to_en_cycles", 32'(k), 32'd8);
      chk("to_err_valid", 32'(err_valid), 32'd1);
      chk("to_err_code", 32'(err_code), 32'd3);
      chk("to_busy", 32'(lsu_busy), 32'd0);
      chk("to_no_resp", 32'(resp_valid), 32'd0);
      tick();

      // done on the 8th cycle wins over the timeout
      req(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd2);
      tick();
      ex_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("to8_ren", 32'(mem_read_enable), 32'd1);
      mem_read_done = 1'b1; mem_read_data = 32'h1234_5678;
      tick();
      mem_read_done = 1'b0;
      chk("to8_resp", 32'(resp_valid), 32'd1);
      chk("to8_data", resp_data, 32'h1234_5678);
      chk("to8_no_err", 32'(err_valid), 32'd0);
      tick();
      chk("to8_no_err2", 32'(err_valid), 32'd0);

      // reset during WAIT
      req(1'b1, 3'b000, 32'h0000_0041, 32'h0000_00A5, 5'd0);
      tick();
      ex_valid = 1'b0;
      chk("sb_mask", 32'(mem_mask_vector), 32'h2);
      chk("sb_wdata", mem_write_data, 32'hA5A5_A5A5);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mr_busy", 32'(lsu_busy), 32'd0);
      chk("mr_en", 32'({mem_read_enable, mem_write_enable}), 32'd0);
      chk("mr_addr", mem_address, 32'h0);
      chk("mr_mask", 32'(mem_mask_vector), 32'h0);
      chk("mr_wdata", mem_write_data, 32'h0);
      chk("mr_rdata", resp_data, 32'h0);
      mem_write_done = 1'b1;
      tick();
      mem_write_done = 1'b0;
      chk("mr_late_done", 32'(resp_valid), 32'd0);
      tick();

      // LHU with wrong done, then back-to-back LB
      req(1'b0, 3'b101, 32'h0000_0006, 32'h0, 5'd9);
      tick();
      ex_valid = 1'b0;
      chk("lhu_mask", 32'(mem_mask_vector), 32'hC);
      mem_write_done = 1'b1;
      tick();
      mem_write_done = 1'b0;
      chk("lhu_wrongdone", 32'(mem_read_enable), 32'd1);
      chk("lhu_wrongdone_resp", 32'(resp_valid), 32'd0);
      mem_read_done = 1'b1; mem_read_data = 32'h8001_0000;
      tick();
      mem_read_done = 1'b0;
      chk("lhu_resp", 32'(resp_valid), 32'd1);
      chk("lhu_data", resp_data, 32'h0000_8001);
      chk("lhu_rd", 32'(resp_rd), 32'd9);
      req(1'b0, 3'b000, 32'h0000_0010, 32'h0, 5'd3);
      tick();
      ex_valid = 1'b0;
      chk("b2b_busy", 32'(lsu_busy), 32'd1);
      chk("b2b_addr", mem_address, 32'h0000_0010);
      chk("b2b_mask", 32'(mem_mask_vector), 32'h1);
      mem_read_done = 1'b1; mem_read_data = 32'hFFFF_FF7F;
      tick();
      mem_read_done = 1'b0;
      chk("b2b_data", resp_data, 32'h0000_007F);
      chk("b2b_rd", 32'(resp_rd), 32'd3);
      tick();

      // done strobes in IDLE are ignored
      mem_read_done = 1'b1; mem_write_done = 1'b1;
      tick();
      mem_read_done = 1'b0; mem_write_done = 1'b0;
      chk("idle_done", 32'({resp_valid, lsu_busy}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
